// File: rtl/lane_frame_sync_ctrl.sv
// Per-lane framing controller: drives decoder resync, hunts metaframe sync.
// Optional statistics counters are built when LANE_SYNC_STATS_EN is defined.
module lane_frame_sync_ctrl #(
  parameter int META_LEN         = 2048,
  parameter int LOCK_WORDS       = 4,
  parameter int MISS_LIMIT       = 3,
  parameter int WORDLOCK_TIMEOUT = 65535,
  parameter int RESYNC_HOLD      = 4
) (
  input  logic        USER_CLK,
  input  logic        SYSTEM_RESET_N,
  input  logic        ENABLE,
  input  logic        DEC_LOCKED,
  input  logic        DEC_VALID,
  input  logic [1:0]  DEC_HEADER,
  input  logic [63:0] DEC_DATA,
  output logic        DEC_PASSTHROUGH,
  output logic        FRAME_LOCKED,
  output logic        SYNC_WORD,
  output logic [12:0] WORD_POS,
  output logic [1:0]  STATE,
  output logic [7:0]  RESYNC_COUNT,
  output logic [7:0]  MISS_COUNT
);

  typedef enum logic [1:0] {
    RESYNC     = 2'd0,
    WORD_HUNT  = 2'd1,
    FRAME_HUNT = 2'd2,
    FRAMED     = 2'd3
  } state_e;

  localparam logic [12:0] POS_LAST  = 13'(META_LEN - 1);
  localparam logic [3:0]  HOLD_LAST = 4'(RESYNC_HOLD - 1);
  localparam logic [3:0]  GOOD_LOCK = 4'(LOCK_WORDS);
  localparam logic [3:0]  MISS_MAX  = 4'(MISS_LIMIT);
  localparam logic [15:0] TO_MAX    = 16'(WORDLOCK_TIMEOUT);

  state_e      st_q, st_d;
  logic [3:0]  hold_q, hold_d;
  logic [15:0] to_q, to_d;
  logic [12:0] pos_q, pos_d;
  logic [3:0]  good_q, good_d;
  logic [3:0]  miss_q, miss_d;
  logic        sync_q, sync_d;
  logic        pt_q, fl_q;
  logic        miss_ev;
  logic        is_sync;
  logic        at_wrap;
  logic        unused_data;

  assign is_sync = DEC_VALID && (DEC_HEADER == 2'b10)
                && (DEC_DATA[63:58] == 6'b011110);
  assign at_wrap = (pos_q == POS_LAST);
  assign unused_data = ^DEC_DATA[57:0];

  // Next-state and counter updates; ENABLE low overrides everything.
  always_comb begin
    st_d    = st_q;
    hold_d  = hold_q;
    to_d    = to_q;
    pos_d   = pos_q;
    good_d  = good_q;
    miss_d  = miss_q;
    sync_d  = 1'b0;
    miss_ev = 1'b0;
    if (!ENABLE) begin
      st_d   = RESYNC;
      hold_d = '0;
      to_d   = '0;
      pos_d  = '0;
      good_d = '0;
      miss_d = '0;
    end else begin
      unique case (st_q)
        RESYNC: begin
          if (hold_q == HOLD_LAST) begin
            st_d   = WORD_HUNT;
            hold_d = '0;
            to_d   = '0;
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end
        WORD_HUNT: begin
          if (DEC_LOCKED) begin
            st_d   = FRAME_HUNT;
            to_d   = '0;
            pos_d  = '0;
            good_d = '0;
          end else if (to_q == TO_MAX) begin
            st_d   = RESYNC;
            hold_d = '0;
            to_d   = '0;
          end else begin
            to_d = to_q + 16'd1;
          end
        end
        FRAME_HUNT: begin
          if (!DEC_LOCKED) begin
            st_d   = WORD_HUNT;
            to_d   = '0;
            pos_d  = '0;
            good_d = '0;
            miss_d = '0;
          end else if (DEC_VALID) begin
            if (good_q == 4'd0) begin
              pos_d = '0;
              if (is_sync) good_d = 4'd1;
            end else if (at_wrap) begin
              pos_d = '0;
              if (is_sync) begin
                good_d = good_q + 4'd1;
                if (good_q + 4'd1 == GOOD_LOCK) begin
                  st_d   = FRAMED;
                  good_d = '0;
                  miss_d = '0;
                end
              end else begin
                good_d = '0;
              end
            end else if (is_sync) begin
              pos_d  = '0;
              good_d = 4'd1;
            end else begin
              pos_d = pos_q + 13'd1;
            end
          end
        end
        FRAMED: begin
          if (!DEC_LOCKED) begin
            st_d   = WORD_HUNT;
            to_d   = '0;
            pos_d  = '0;
            good_d = '0;
            miss_d = '0;
          end else if (DEC_VALID) begin
            if (at_wrap) begin
              pos_d = '0;
              if (is_sync) begin
                miss_d = '0;
                sync_d = 1'b1;
              end else begin
                miss_d  = miss_q + 4'd1;
                miss_ev = 1'b1;
                if (miss_q + 4'd1 == MISS_MAX) begin
                  st_d   = RESYNC;
                  hold_d = '0;
                  miss_d = '0;
                end
              end
            end else begin
              pos_d = pos_q + 13'd1;
            end
          end
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      st_q   <= RESYNC;
      hold_q <= '0;
      to_q   <= '0;
      pos_q  <= '0;
      good_q <= '0;
      miss_q <= '0;
      sync_q <= 1'b0;
      pt_q   <= 1'b1;
      fl_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      hold_q <= hold_d;
      to_q   <= to_d;
      pos_q  <= pos_d;
      good_q <= good_d;
      miss_q <= miss_d;
      sync_q <= sync_d;
      pt_q   <= (st_d == RESYNC);
      fl_q   <= (st_d == FRAMED);
    end
  end

  assign STATE           = st_q;
  assign DEC_PASSTHROUGH = pt_q;
  assign FRAME_LOCKED    = fl_q;
  assign SYNC_WORD       = sync_q;
  assign WORD_POS        = pos_q;

`ifdef LANE_SYNC_STATS_EN
  logic [7:0] rcnt_q;
  logic [7:0] mcnt_q;

  // Saturating resync-entry and missed-sync counters.
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      rcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      if (st_d == RESYNC && st_q != RESYNC && rcnt_q != 8'hFF)
        rcnt_q <= rcnt_q + 8'd1;
      if (miss_ev && mcnt_q != 8'hFF)
        mcnt_q <= mcnt_q + 8'd1;
    end
  end

  assign RESYNC_COUNT = rcnt_q;
  assign MISS_COUNT   = mcnt_q;
`else
  logic unused_stats;
  assign unused_stats = miss_ev;
  assign RESYNC_COUNT = '0;
  assign MISS_COUNT   = '0;
`endif

endmodule

// File: tb/tb_lane_frame_sync_ctrl.sv
// Bench for lane_frame_sync_ctrl: vector table, corner sequences,
// and random traffic against a word-counting reference model.
module tb_lane_frame_sync_ctrl;

  localparam int ML = 8;
  localparam int LW = 4;
  localparam int MX = 3;
  localparam int TO = 16;
  localparam int RH = 4;
`ifdef LANE_SYNC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        lk;
  logic        vld;
  logic [1:0]  hdr;
  logic [63:0] dat;
  logic        pt;
  logic        fl;
  logic        sw;
  logic [12:0] pos;
  logic [1:0]  st;
  logic [7:0]  rcnt;
  logic [7:0]  mcnt;

  lane_frame_sync_ctrl #(
    .META_LEN(ML),
    .LOCK_WORDS(LW),
    .MISS_LIMIT(MX),
    .WORDLOCK_TIMEOUT(TO),
    .RESYNC_HOLD(RH)
  ) dut (
    .USER_CLK(clk),
    .SYSTEM_RESET_N(rst_n),
    .ENABLE(en),
    .DEC_LOCKED(lk),
    .DEC_VALID(vld),
    .DEC_HEADER(hdr),
    .DEC_DATA(dat),
    .DEC_PASSTHROUGH(pt),
    .FRAME_LOCKED(fl),
    .SYNC_WORD(sw),
    .WORD_POS(pos),
    .STATE(st),
    .RESYNC_COUNT(rcnt),
    .MISS_COUNT(mcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: counts cycles and valid words, no state encoding
  int m_state;
  int m_hold;
  int m_wait;
  int m_good;
  int m_since;
  int m_miss;
  int m_rcnt;
  int m_mcnt;
  bit m_sw;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40)
        $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_hold = 0; m_wait = 0; m_good = 0;
    m_since = 0; m_miss = 0; m_rcnt = 0; m_mcnt = 0; m_sw = 0;
  endtask

  task automatic m_clear();
    m_good = 0; m_since = 0; m_miss = 0; m_wait = 0; m_hold = 0;
  endtask

  task automatic m_step(input bit e, input bit l, input bit v, input bit s);
    int prev;
    prev = m_state;
    m_sw = 0;
    if (!e) begin
      m_state = 0;
      m_clear();
    end else if (m_state == 0) begin
      m_hold++;
      if (m_hold >= RH) begin
        m_state = 1;
        m_clear();
      end
    end else if (m_state == 1) begin
      m_wait++;
      if (l) begin
        m_state = 2;
        m_clear();
      end else if (m_wait > TO) begin
        m_state = 0;
        m_clear();
      end
    end else if (!l) begin
      m_state = 1;
      m_clear();
    end else if (v) begin
      if (m_state == 2 && m_good == 0) begin
        if (s) m_good = 1;
        m_since = 0;
      end else begin
        m_since++;
        if (m_since % ML == 0) begin
          if (m_state == 2) begin
            if (s) m_good++;
            else m_good = 0;
            if (m_good == LW) begin
              m_state = 3;
              m_clear();
            end
          end else if (s) begin
            m_miss = 0;
            m_sw = 1;
          end else begin
            m_miss++;
            if (m_mcnt < 255) m_mcnt++;
            if (m_miss == MX) begin
              m_state = 0;
              m_clear();
            end
          end
        end else if (m_state == 2 && s) begin
          m_good = 1;
          m_since = 0;
        end
      end
    end
    if (m_state == 0 && prev != 0 && m_rcnt < 255) m_rcnt++;
  endtask

  task automatic cmp_model();
    chk("state", 32'(st), 32'(m_state));
    chk("passthru", 32'(pt), 32'(m_state == 0));
    chk("locked", 32'(fl), 32'(m_state == 3));
    chk("syncword", 32'(sw), 32'(m_sw));
    chk("wordpos", 32'(pos), 32'(m_since % ML));
    chk("rcount", 32'(rcnt), STATS ? 32'(m_rcnt) : 32'd0);
    chk("mcount", 32'(mcnt), STATS ? 32'(m_mcnt) : 32'd0);
  endtask

  // kind: 0 data, 1 sync, 2 corrupted sync, 3 idle
  task automatic cycle(input bit e, input bit l, input int kind);
    logic [63:0] d;
    logic [1:0]  h;
    bit          s;
    d = {$urandom, $urandom};
    h = ($urandom_range(1) != 0) ? 2'b10 : 2'b01;
    if (kind == 0 && d[63:58] == 6'b011110) d[63] = 1'b1;
    if (kind == 1) h = 2'b10;
    if (kind == 2) h = 2'b01;
    if (kind != 0) d[63:58] = 6'b011110;
    if (kind == 3) h = 2'b10;
    en = e; lk = l; vld = (kind != 3); hdr = h; dat = d;
    s = (kind == 1);
    @(posedge clk);
    m_step(e, l, kind != 3, s);
    #1;
    cmp_model();
  endtask

  typedef struct {
    bit         l;
    int         kind;
    logic [1:0] st;
    bit         pt;
    bit         fl;
    bit         sw;
    logic [12:0] pos;
  } vec_t;

  vec_t tbl[46];

  initial begin
    for (int k = 0; k < 5; k++) begin
      tbl[k].l = 1; tbl[k].kind = 3; tbl[k].fl = 0; tbl[k].sw = 0;
      tbl[k].pos = 0;
      tbl[k].st = (k < 3) ? 2'd0 : (k == 3) ? 2'd1 : 2'd2;
      tbl[k].pt = (k < 3);
    end
    for (int i = 0; i < 41; i++) begin
      tbl[i+5].l = 1;
      tbl[i+5].kind = (i % 8 == 0) ? 1 : 0;
      tbl[i+5].st = (i >= 24) ? 2'd3 : 2'd2;
      tbl[i+5].pt = 0;
      tbl[i+5].fl = (i >= 24);
      tbl[i+5].sw = (i >= 32) && (i % 8 == 0);
      tbl[i+5].pos = 13'(i % 8);
    end

    rst_n = 0; en = 1; lk = 1; vld = 0; hdr = 0; dat = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(st), 0);
    chk("rst_pt", 32'(pt), 1);
    chk("rst_fl", 32'(fl), 0);
    chk("rst_sw", 32'(sw), 0);
    chk("rst_pos", 32'(pos), 0);
    chk("rst_rcnt", 32'(rcnt), 0);
    chk("rst_mcnt", 32'(mcnt), 0);
    rst_n = 1;

    // reset release, then frame lock with sync every 8 words
    for (int k = 0; k < 46; k++) begin
      cycle(1'b1, tbl[k].l, tbl[k].kind);
      chk("tbl_state", 32'(st), 32'(tbl[k].st));
      chk("tbl_pt", 32'(pt), 32'(tbl[k].pt));
      chk("tbl_fl", 32'(fl), 32'(tbl[k].fl));
      chk("tbl_sw", 32'(sw), 32'(tbl[k].sw));
      chk("tbl_pos", 32'(pos), 32'(tbl[k].pos));
    end

    // three corrupted expected sync words drop to resync
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 7; j++) cycle(1'b1, 1'b1, 0);
      cycle(1'b1, 1'b1, 2);
      chk("miss_cnt", 32'(mcnt), STATS ? 32'(r + 1) : 0);
    end
    chk("miss_state", 32'(st), 0);
    chk("miss_pt", 32'(pt), 1);
    chk("miss_rcnt", 32'(rcnt), STATS ? 32'd1 : 0);
    for (int j = 1; j <= 4; j++) begin
      cycle(1'b1, 1'b0, 3);
      chk("hold_pt", 32'(pt), 32'(j < 4));
    end
    chk("hold_exit", 32'(st), 1);

    // word-lock timeout loop until resync count saturates
    for (int p = 0; p < 260; p++) begin
      for (int c = 0; c < 21; c++) begin
        cycle(1'b1, 1'b0, 3);
        if (p == 0 && c == 15) chk("to_still_hunt", 32'(st), 1);
        if (p == 0 && c == 16) chk("to_fire", 32'(st), 0);
        if (p == 0 && c == 20) chk("to_period", 32'(st), 1);
      end
    end
    chk("rcnt_sat", 32'(rcnt), STATS ? 32'd255 : 0);

    // lock arriving on the timeout cycle wins
    for (int c = 0; c < 16; c++) cycle(1'b1, 1'b0, 3);
    cycle(1'b1, 1'b1, 3);
    chk("lock_wins", 32'(st), 2);

    // candidate restart by a sync at position 5
    cycle(1'b1, 1'b1, 1);
    for (int j = 0; j < 7; j++) cycle(1'b1, 1'b1, 0);
    cycle(1'b1, 1'b1, 1);
    for (int j = 0; j < 4; j++) cycle(1'b1, 1'b1, 0);
    chk("pre_restart_pos", 32'(pos), 4);
    cycle(1'b1, 1'b1, 1);
    chk("restart_pos", 32'(pos), 0);
    for (int k = 1; k <= 3; k++) begin
      for (int j = 0; j < 7; j++) cycle(1'b1, 1'b1, 0);
      cycle(1'b1, 1'b1, 1);
      chk("restart_state", 32'(st), (k < 3) ? 2 : 3);
    end
    chk("restart_fl", 32'(fl), 1);

    // enable drop beats decoder lock loss
    cycle(1'b0, 1'b0, 3);
    chk("en_prio_state", 32'(st), 0);
    chk("en_prio_pt", 32'(pt), 1);

    // random traffic from a framed source with impairments
    begin
      int src;
      int kind;
      bit e;
      bit l;
      src = 0;
      for (int n = 0; n < 4000; n++) begin
        if (n == 2000) begin
          rst_n = 0;
          #1;
          m_reset();
          chk("midrst_state", 32'(st), 0);
          chk("midrst_pt", 32'(pt), 1);
          @(posedge clk);
          #1;
          rst_n = 1;
        end
        e = ($urandom_range(199) != 0);
        l = ($urandom_range(99) > 1);
        if ($urandom_range(9) < 2) begin
          kind = 3;
        end else begin
          if (src % ML == 0)
            kind = ($urandom_range(9) != 0) ? 1 : 2;
          else
            kind = ($urandom_range(39) == 0) ? 1 : 0;
          src++;
        end
        cycle(e, l, kind);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
